// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared AHB-Lite types and constants for the two-manager arbiter
package ahb_arb_pkg;

   localparam int unsigned AHB_ADDR_MAX = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef struct packed {
      logic [AHB_ADDR_MAX-1:0] haddr;
      htrans_e                 htrans;
      logic                    hwrite;
      logic [2:0]              hsize;
      logic [2:0]              hburst;
      logic [3:0]              hprot;
   } ahb_aphase_t;

endpackage

// File: rtl/ahb_arb_hold_stage.sv
// rtl/ahb_arb_hold_stage.sv - per-manager hold register, pending flag and request generation
module ahb_arb_hold_stage
   import ahb_arb_pkg::*;
(
   input  logic        hclk_i,
   input  logic        hresetn_i,
   input  ahb_aphase_t live_i,
   input  logic        hsel_i,
   input  logic        hreadyout_i,
   input  logic        grant_i,
   input  logic        s_hreadyout_i,
   output ahb_aphase_t aphase_o,
   output logic        hsel_o,
   output logic        req_o,
   output logic        pend_o
);

   ahb_aphase_t hold_q, hold_d;
   logic        pend_q, pend_d;
   logic        live_req;
   logic        capture;

   // BUSY has htrans[1]=0, so it never counts as a live request and is never held
   always_comb begin
      live_req = hsel_i & live_i.htrans[1] & hreadyout_i;
      capture  = ~pend_q & live_req & ~(grant_i & s_hreadyout_i);
      pend_d   = pend_q;
      hold_d   = hold_q;
      if (capture) begin
         pend_d = 1'b1;
         hold_d = live_i;
      end else if (pend_q & grant_i & s_hreadyout_i) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge hclk_i) begin
      if (!hresetn_i) begin
         pend_q <= 1'b0;
         hold_q <= '0;
      end else begin
         pend_q <= pend_d;
         hold_q <= hold_d;
      end
   end

   assign aphase_o = pend_q ? hold_q : live_i;
   assign hsel_o   = pend_q | hsel_i;
   assign req_o    = pend_q | live_req;
   assign pend_o   = pend_q;

endmodule

// File: rtl/ahb_lite_arbiter.sv
// rtl/ahb_lite_arbiter.sv - two-manager to one-subordinate AHB5-Lite arbiter top
module ahb_lite_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic [ADDR_W-1:0] m0_haddr,
   input  logic [1:0]        m0_htrans,
   input  logic              m0_hwrite,
   input  logic [2:0]        m0_hsize,
   input  logic [2:0]        m0_hburst,
   input  logic [3:0]        m0_hprot,
   input  logic              m0_hsel,
   input  logic [DATA_W-1:0] m0_hwdata,
   output logic [DATA_W-1:0] m0_hrdata,
   output logic              m0_hreadyout,
   output logic              m0_hresp,
   input  logic [ADDR_W-1:0] m1_haddr,
   input  logic [1:0]        m1_htrans,
   input  logic              m1_hwrite,
   input  logic [2:0]        m1_hsize,
   input  logic [2:0]        m1_hburst,
   input  logic [3:0]        m1_hprot,
   input  logic              m1_hsel,
   input  logic [DATA_W-1:0] m1_hwdata,
   output logic [DATA_W-1:0] m1_hrdata,
   output logic              m1_hreadyout,
   output logic              m1_hresp,
   output logic [ADDR_W-1:0] s_haddr,
   output logic [1:0]        s_htrans,
   output logic              s_hwrite,
   output logic [2:0]        s_hsize,
   output logic [2:0]        s_hburst,
   output logic [3:0]        s_hprot,
   output logic              s_hsel,
   output logic [DATA_W-1:0] s_hwdata,
   output logic              s_hready,
   input  logic              s_hreadyout,
   input  logic [DATA_W-1:0] s_hrdata,
   input  logic              s_hresp
);

   ahb_aphase_t live0, live1, ph0, ph1, owner_ph, gnt_ph, out_ph;
   ahb_aphase_t park_q;
   logic        hsel0, hsel1, req0, req1, pend0, pend1;
   logic        owner_hsel, gnt_req;
   logic        last_grant_q, addr_active_q, data_owner_q, data_valid_q;
   logic        grant, lock, fwd;

   always_comb begin
      live0 = '0;
      live0.haddr[ADDR_W-1:0] = m0_haddr;
      live0.htrans = htrans_e'(m0_htrans);
      live0.hwrite = m0_hwrite;
      live0.hsize  = m0_hsize;
      live0.hburst = m0_hburst;
      live0.hprot  = m0_hprot;
      live1 = '0;
      live1.haddr[ADDR_W-1:0] = m1_haddr;
      live1.htrans = htrans_e'(m1_htrans);
      live1.hwrite = m1_hwrite;
      live1.hsize  = m1_hsize;
      live1.hburst = m1_hburst;
      live1.hprot  = m1_hprot;
   end

   ahb_arb_hold_stage u_hold0 (
      .hclk_i(hclk), .hresetn_i(hresetn), .live_i(live0), .hsel_i(m0_hsel),
      .hreadyout_i(m0_hreadyout), .grant_i(grant == 1'b0), .s_hreadyout_i(s_hreadyout),
      .aphase_o(ph0), .hsel_o(hsel0), .req_o(req0), .pend_o(pend0)
   );

   ahb_arb_hold_stage u_hold1 (
      .hclk_i(hclk), .hresetn_i(hresetn), .live_i(live1), .hsel_i(m1_hsel),
      .hreadyout_i(m1_hreadyout), .grant_i(grant == 1'b1), .s_hreadyout_i(s_hreadyout),
      .aphase_o(ph1), .hsel_o(hsel1), .req_o(req1), .pend_o(pend1)
   );

   // The owner keeps the bus while its burst continues with SEQ/BUSY; wait states freeze the grant
   always_comb begin
      owner_ph   = last_grant_q ? ph1 : ph0;
      owner_hsel = last_grant_q ? hsel1 : hsel0;
      lock       = addr_active_q & owner_hsel &
                   ((owner_ph.htrans == SEQ) || (owner_ph.htrans == BUSY));
      if (!s_hreadyout || lock) begin
         grant = last_grant_q;
      end else if (req0 && req1) begin
         grant = ~last_grant_q;
      end else if (req0) begin
         grant = 1'b0;
      end else if (req1) begin
         grant = 1'b1;
      end else begin
         grant = last_grant_q;
      end
      gnt_ph  = grant ? ph1 : ph0;
      gnt_req = grant ? req1 : req0;
      fwd     = gnt_req | lock;
      out_ph  = fwd ? gnt_ph : park_q;
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         last_grant_q  <= 1'b1;
         addr_active_q <= 1'b0;
         data_owner_q  <= 1'b0;
         data_valid_q  <= 1'b0;
         park_q        <= '0;
      end else if (s_hreadyout) begin
         last_grant_q  <= grant;
         addr_active_q <= fwd;
         data_owner_q  <= grant;
         data_valid_q  <= fwd & gnt_ph.htrans[1];
         if (fwd) begin
            park_q <= gnt_ph;
         end
      end
   end

   assign s_haddr  = out_ph.haddr[ADDR_W-1:0];
   assign s_htrans = fwd ? out_ph.htrans : IDLE;
   assign s_hwrite = out_ph.hwrite;
   assign s_hsize  = out_ph.hsize;
   assign s_hburst = out_ph.hburst;
   assign s_hprot  = out_ph.hprot;
   assign s_hsel   = fwd;
   assign s_hwdata = data_owner_q ? m1_hwdata : m0_hwdata;
   assign s_hready = s_hreadyout;

   assign m0_hrdata    = s_hrdata;
   assign m1_hrdata    = s_hrdata;
   assign m0_hreadyout = (data_valid_q && !data_owner_q) ? s_hreadyout : ~pend0;
   assign m1_hreadyout = (data_valid_q &&  data_owner_q) ? s_hreadyout : ~pend1;
   assign m0_hresp     = (data_valid_q && !data_owner_q) ? s_hresp : HRESP_OKAY;
   assign m1_hresp     = (data_valid_q &&  data_owner_q) ? s_hresp : HRESP_OKAY;

endmodule

// File: doc/ahb_lite_arbiter.md
# ahb_lite_arbiter

Two-manager to one-subordinate AHB5-Lite arbiter. It shares a single subordinate port between two AHB-Lite managers. Each manager keeps the AHB-Lite view that it owns the bus: a losing manager's address phase is captured in a hold stage, and the manager is stalled through its own HREADYOUT until that transfer completes at the subordinate. The block sits between agent-driven or RTL managers and a shared peripheral or memory port.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width (32 or 64).
- `hclk` in, 1: clock.
- `hresetn` in, 1: synchronous, active-low reset.
- `m0_/m1_ haddr, htrans, hwrite, hsize, hburst, hprot, hsel` in, ADDR_W/2/1/3/3/4/1: manager address phase.
- `m0_/m1_ hwdata` in, DATA_W: manager write data.
- `m0_/m1_ hrdata` out, DATA_W: equals `s_hrdata`, broadcast to both managers.
- `m0_/m1_ hreadyout` out, 1: per-manager HREADY.
- `m0_/m1_ hresp` out, 1: per-manager response.
- `s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hsel` out: subordinate address phase.
- `s_hwdata` out, DATA_W: data-phase owner's `hwdata`.
- `s_hready` out, 1: equals `s_hreadyout`.
- `s_hreadyout` in, 1; `s_hrdata` in, DATA_W; `s_hresp` in, 1: subordinate response.

## Operation
- **Request from manager i:** `req_i = pend_i | (mi_hsel & mi_htrans[1] & mi_hreadyout)`.
- **Arbitration point:** the cycle `s_hreadyout=1`.
  - Round-robin: priority goes to the manager not granted last. `last_grant` resets to 1, so m0 wins first.
- **Burst lock:** while the current address owner presents SEQ or BUSY, it keeps the grant and the other manager is not considered. Re-arbitration happens only when the owner presents IDLE or NONSEQ.
- **Address source:** the granted manager's hold register when `pend` is set, otherwise its live bus.
  - With no request, the bus parks on the last owner's address with `s_htrans=IDLE` and `s_hsel=0`.
- **Hold capture:** a live request that is not forwarded this cycle is captured into `hold_i` and `pend_i` is set. Causes: the other manager won, the lock is held, or `s_hreadyout=0`.
  - `pend_i` clears on the cycle the held phase is accepted (granted and `s_hreadyout=1`).
- **Data-phase tracking:** on `s_hreadyout=1`, register `data_owner` and `data_valid` (the forwarded phase was NONSEQ or SEQ with `hsel`).
- **mi_hreadyout:**
  - `s_hreadyout` if `data_valid && data_owner==i`;
  - else 0 if `pend_i`;
  - else 1.
- **mi_hresp:** `s_hresp` when manager i is data owner, else 0.
- **ERROR responses** pass through unchanged, two cycles. A manager cancelling its next transfer with IDLE in the second error cycle needs no special handling.
- **BUSY** is forwarded only from the locked owner and never captured into a hold register.

## Timing
- **Reset values:**
  - `s_htrans=0`, `s_hsel=0`, `s_haddr=0`, other `s_*` address fields 0;
  - `mi_hreadyout=1`, `mi_hresp=0`;
  - `pend=0`, `data_valid=0`, lock=0.
- **Granted live request:** zero added latency; the address reaches `s_*` combinationally in the same cycle.
- **Held request:** captured at edge N and forwarded no earlier than cycle N+1. The manager sees `hreadyout=0` from N+1 until its data phase completes.
- **Back-to-back:** an owner whose data phase completes may present its next address in the same cycle; if granted it is forwarded with no bubble.
- **Simultaneous NONSEQ from both managers:** one is forwarded, the other is held. No transfer is lost or duplicated.
- **Subordinate wait states** (`s_hreadyout=0`) freeze `data_owner`, grant and lock. New live requests are held.
- **Reset mid-transfer:** at the next edge all state clears and outputs return to reset values. In-flight and held transfers are abandoned.

## Structure
- Package `ahb_arb_pkg`:
  - `htrans_e` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - `hburst` constants with SINGLE=0;
  - `HRESP_OKAY=0`, `HRESP_ERROR=1`;
  - struct `ahb_aphase_t` {haddr, htrans, hwrite, hsize, hburst, hprot}.
- Sub-module `ahb_arb_hold_stage`, instantiated per manager:
  - contains the hold register, `pend` flag and request generation;
  - outputs the selected `ahb_aphase_t` and `req`.
- The top level contains round-robin, lock, `data_owner` and the response muxes.

## Test plan
- **Single manager:** m0 NONSEQ write 0x100 data 0xDEADBEEF, m1 idle → `s_haddr=0x100` in the same cycle, `s_hwdata=0xDEADBEEF` the next cycle, `m1_hreadyout` stays 1.
- **Simultaneous request after reset:** m0 and m1 issue NONSEQ together → m0 forwarded first; m1 held with `m1_hreadyout=0`; m1's address 0x200 is forwarded the next cycle and completes with the correct `hrdata`.
- **Burst lock:** m0 INCR4 at 0x0 while m1 requests at beat 2 → all 4 beats of m0 are contiguous, m1 is forwarded after the 4th beat, and `hburst`/`haddr` are preserved from the hold register.
- **Wait states:** subordinate inserts 3 wait states on m1 read data 0x12345678 → only `m1_hreadyout` is low; m0 request captured in that window is forwarded after completion.
- **Error response:** `s_hresp=1` for 2 cycles on an m0 transfer → `m0_hresp` follows it; m1 sees `hresp=0`; m0's IDLE in the second error cycle issues nothing.
- **Reset with pending:** `hresetn=0` with m1 pending → next edge `pend=0`, `s_htrans=IDLE`, `m1_hreadyout=1`, and the first grant after reset goes to m0.
